// File: rtl/dsp_wresp_arbiter.sv
// Per-master write-response arbiter: round-robin merge of per-slave B channels into one registered master B slice.
// Optional saturating error-response counter (err_cnt_o) enabled by defining DSP_WRESP_ERR_CNT_EN.
module dsp_wresp_arbiter #(
  parameter int SLV_AMT         = 2,
  parameter int SLV_ID_W        = (SLV_AMT > 1) ? $clog2(SLV_AMT) : 1,
  parameter int TRANS_MST_ID_W  = 5,
  parameter int TRANS_WR_RESP_W = 2
) (
  input  logic                                ACLK_i,
  input  logic                                ARESETn_i,
  input  logic [TRANS_MST_ID_W*SLV_AMT-1:0]   sa_BID_i,
  input  logic [TRANS_WR_RESP_W*SLV_AMT-1:0]  sa_BRESP_i,
  input  logic [SLV_AMT-1:0]                  sa_BVALID_i,
  output logic [SLV_AMT-1:0]                  sa_BREADY_o,
  output logic [TRANS_MST_ID_W-1:0]           m_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]          m_BRESP_o,
  output logic                                m_BVALID_o,
  input  logic                                m_BREADY_i
`ifdef DSP_WRESP_ERR_CNT_EN
  ,
  output logic [15:0]                         err_cnt_o
`endif
);

  logic                       m_bvalid_q, m_bvalid_d;
  logic [TRANS_MST_ID_W-1:0]  m_bid_q, m_bid_d;
  logic [TRANS_WR_RESP_W-1:0] m_bresp_q, m_bresp_d;
  logic [SLV_ID_W-1:0]        rr_ptr_q, rr_ptr_d;

  logic                       load_en;
  logic                       grant_any;
  logic [SLV_AMT-1:0]         grant;
  logic [SLV_ID_W-1:0]        grant_idx;
  logic [SLV_ID_W:0]          cand;
  logic [SLV_ID_W:0]          nxt_ptr;
  logic [TRANS_MST_ID_W-1:0]  sel_id;
  logic [TRANS_WR_RESP_W-1:0] sel_resp;

  // Reset is folded in so no slave sees BREADY while the block is held in reset.
  assign load_en     = ARESETn_i & (~m_bvalid_q | m_BREADY_i);
  assign sa_BREADY_o = grant & {SLV_AMT{load_en}};

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < SLV_AMT; i++) begin
      cand = {1'b0, rr_ptr_q} + (SLV_ID_W+1)'(i);
      if (cand >= (SLV_ID_W+1)'(SLV_AMT)) cand = cand - (SLV_ID_W+1)'(SLV_AMT);
      if (!grant_any && sa_BVALID_i[cand[SLV_ID_W-1:0]]) begin
        grant[cand[SLV_ID_W-1:0]] = 1'b1;
        grant_idx                 = cand[SLV_ID_W-1:0];
        grant_any                 = 1'b1;
      end
    end
  end

  always_comb begin
    sel_id   = '0;
    sel_resp = '0;
    for (int s = 0; s < SLV_AMT; s++) begin
      if (grant[s]) begin
        sel_id   = sa_BID_i[TRANS_MST_ID_W*s +: TRANS_MST_ID_W];
        sel_resp = sa_BRESP_i[TRANS_WR_RESP_W*s +: TRANS_WR_RESP_W];
      end
    end
  end

  always_comb begin
    nxt_ptr = {1'b0, grant_idx} + (SLV_ID_W+1)'(1);
    if (nxt_ptr == (SLV_ID_W+1)'(SLV_AMT)) nxt_ptr = '0;

    m_bvalid_d = m_bvalid_q;
    m_bid_d    = m_bid_q;
    m_bresp_d  = m_bresp_q;
    rr_ptr_d   = rr_ptr_q;
    if (grant_any && load_en) begin
      m_bvalid_d = 1'b1;
      m_bid_d    = sel_id;
      m_bresp_d  = sel_resp;
      rr_ptr_d   = nxt_ptr[SLV_ID_W-1:0];
    end else if (m_BREADY_i) begin
      m_bvalid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) begin
      m_bvalid_q <= 1'b0;
      m_bid_q    <= '0;
      m_bresp_q  <= '0;
      rr_ptr_q   <= '0;
    end else begin
      m_bvalid_q <= m_bvalid_d;
      m_bid_q    <= m_bid_d;
      m_bresp_q  <= m_bresp_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign m_BVALID_o = m_bvalid_q;
  assign m_BID_o    = m_bid_q;
  assign m_BRESP_o  = m_bresp_q;

`ifdef DSP_WRESP_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // BRESP[1] set marks SLVERR/DECERR; counted when the master accepts the beat.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (m_bvalid_q && m_BREADY_i && m_bresp_q[1] && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge ACLK_i or negedge ARESETn_i) begin
    if (!ARESETn_i) err_cnt_q <= '0;
    else            err_cnt_q <= err_cnt_d;
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_dsp_wresp_arbiter.sv
// Self-checking bench for dsp_wresp_arbiter (3 slaves): directed scenarios plus sticky-valid random traffic
// compared against a transaction-level model of the response slice and round-robin pointer.
module tb_dsp_wresp_arbiter;

  localparam int N   = 3;
  localparam int IDW = 5;
  localparam int RW  = 2;

  logic               clk = 1'b0;
  logic               rstn;
  logic [IDW*N-1:0]   sa_BID_i;
  logic [RW*N-1:0]    sa_BRESP_i;
  logic [N-1:0]       sa_BVALID_i;
  logic [N-1:0]       sa_BREADY_o;
  logic [IDW-1:0]     m_BID_o;
  logic [RW-1:0]      m_BRESP_o;
  logic               m_BVALID_o;
  logic               m_BREADY_i;
`ifdef DSP_WRESP_ERR_CNT_EN
  logic [15:0]        err_cnt_o;
`endif

  dsp_wresp_arbiter #(.SLV_AMT(N), .TRANS_MST_ID_W(IDW), .TRANS_WR_RESP_W(RW)) u_dut (
    .ACLK_i      (clk),
    .ARESETn_i   (rstn),
    .sa_BID_i    (sa_BID_i),
    .sa_BRESP_i  (sa_BRESP_i),
    .sa_BVALID_i (sa_BVALID_i),
    .sa_BREADY_o (sa_BREADY_o),
    .m_BID_o     (m_BID_o),
    .m_BRESP_o   (m_BRESP_o),
    .m_BVALID_o  (m_BVALID_o),
    .m_BREADY_i  (m_BREADY_i)
`ifdef DSP_WRESP_ERR_CNT_EN
    ,
    .err_cnt_o   (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  // Reference model: pending response per slave, contents of the output slice, next favoured slave.
  bit             pend_v[N];
  logic [IDW-1:0] pend_id[N];
  logic [RW-1:0]  pend_resp[N];
  bit             exp_v;
  logic [IDW-1:0] exp_id;
  logic [RW-1:0]  exp_resp;
  int             ptr;
  int             exp_err;
  logic [N-1:0]   exp_ready;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic setPend(input int s, input logic [IDW-1:0] id, input logic [RW-1:0] resp);
    pend_v[s]    = 1'b1;
    pend_id[s]   = id;
    pend_resp[s] = resp;
  endtask

  task automatic driveInputs(input bit bready);
    for (int s = 0; s < N; s++) begin
      sa_BVALID_i[s]            = pend_v[s];
      sa_BID_i[s*IDW +: IDW]    = pend_id[s];
      sa_BRESP_i[s*RW +: RW]    = pend_resp[s];
    end
    m_BREADY_i = bready;
  endtask

  // One bus cycle: drive at negedge, check just after, then advance the model to the next edge.
  task automatic applyStimulus(input bit bready);
    int best;
    int bestd;
    int d;
    @(negedge clk);
    driveInputs(bready);
    #1;
    best  = -1;
    bestd = N;
    for (int s = 0; s < N; s++) begin
      if (pend_v[s]) begin
        d = (s - ptr + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = s;
        end
      end
    end
    exp_ready = '0;
    if ((!exp_v || bready) && best >= 0) exp_ready[best] = 1'b1;
    checkOutput("sa_bready", 32'(sa_BREADY_o), 32'(exp_ready));
    checkOutput("m_bvalid", 32'(m_BVALID_o), 32'(exp_v));
    if (exp_v) begin
      checkOutput("m_bid", 32'(m_BID_o), 32'(exp_id));
      checkOutput("m_bresp", 32'(m_BRESP_o), 32'(exp_resp));
    end
`ifdef DSP_WRESP_ERR_CNT_EN
    checkOutput("err_cnt", 32'(err_cnt_o), 32'(exp_err));
    if (exp_v && bready && exp_resp[1] && exp_err < 65535) exp_err++;
`endif
    if (exp_ready != '0) begin
      exp_v        = 1'b1;
      exp_id       = pend_id[best];
      exp_resp     = pend_resp[best];
      ptr          = (best + 1) % N;
      pend_v[best] = 1'b0;
    end else if (bready) begin
      exp_v = 1'b0;
    end
  endtask

  // Asynchronous reset asserted mid-cycle; slice must empty at once.
  task automatic doReset();
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("rst_bvalid", 32'(m_BVALID_o), 32'd0);
    checkOutput("rst_bready", 32'(sa_BREADY_o), 32'd0);
    for (int s = 0; s < N; s++) pend_v[s] = 1'b0;
    exp_v   = 1'b0;
    ptr     = 0;
    exp_err = 0;
    @(negedge clk);
    driveInputs(1'b0);
    rstn = 1'b1;
  endtask

  initial begin
    int ord[6];
    ord = '{0, 1, 2, 0, 1, 2};
    rstn        = 1'b0;
    sa_BVALID_i = '1;
    sa_BID_i    = '1;
    sa_BRESP_i  = '1;
    m_BREADY_i  = 1'b1;
    exp_v       = 1'b0;
    exp_id      = '0;
    exp_resp    = '0;
    ptr         = 0;
    exp_err     = 0;
    for (int s = 0; s < N; s++) begin
      pend_v[s]    = 1'b0;
      pend_id[s]   = '0;
      pend_resp[s] = '0;
    end

    #3;
    checkOutput("init_bvalid", 32'(m_BVALID_o), 32'd0);
    checkOutput("init_bid", 32'(m_BID_o), 32'd0);
    checkOutput("init_bresp", 32'(m_BRESP_o), 32'd0);
    checkOutput("init_bready", 32'(sa_BREADY_o), 32'd0);
    @(negedge clk);
    driveInputs(1'b0);
    @(negedge clk);
    rstn = 1'b1;

    $display("[TB] single beat from slave 1");
    setPend(1, 5'h0A, 2'b00);
    applyStimulus(1'b1);
    checkOutput("single_ready", 32'(sa_BREADY_o), 32'b010);
    applyStimulus(1'b1);
    checkOutput("single_bid", 32'(m_BID_o), 32'h0A);
    checkOutput("single_bvalid", 32'(m_BVALID_o), 32'd1);

    $display("[TB] round-robin fairness");
    doReset();
    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < N; s++) if (!pend_v[s]) setPend(s, 5'(k*4 + s), 2'(s));
      applyStimulus(1'b1);
      checkOutput("rr_order", 32'(sa_BREADY_o), 32'(1 << ord[k]));
      if (k > 0) checkOutput("rr_no_bubble", 32'(m_BVALID_o), 32'd1);
    end

    $display("[TB] back-pressure");
    doReset();
    setPend(2, 5'h03, 2'b01);
    applyStimulus(1'b0);
    setPend(0, 5'h07, 2'b00);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0);
      checkOutput("stall_ready", 32'(sa_BREADY_o), 32'd0);
      checkOutput("stall_bid", 32'(m_BID_o), 32'h03);
    end
    applyStimulus(1'b1);
    checkOutput("release_ready", 32'(sa_BREADY_o), 32'b001);
    applyStimulus(1'b1);
    checkOutput("release_bid", 32'(m_BID_o), 32'h07);
    checkOutput("release_bvalid", 32'(m_BVALID_o), 32'd1);

    $display("[TB] wrap and skip");
    doReset();
    setPend(1, 5'h11, 2'b00);
    applyStimulus(1'b1);
    setPend(1, 5'h12, 2'b01);
    applyStimulus(1'b1);
    checkOutput("wrap_ready", 32'(sa_BREADY_o), 32'b010);
    setPend(0, 5'h13, 2'b00);
    setPend(2, 5'h14, 2'b00);
    applyStimulus(1'b1);
    checkOutput("wrap_ptr_next", 32'(sa_BREADY_o), 32'b100);

    $display("[TB] reset while slice full");
    doReset();
    setPend(2, 5'h1F, 2'b11);
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    checkOutput("pre_rst_full", 32'(m_BVALID_o), 32'd1);
    doReset();
    for (int s = 0; s < N; s++) setPend(s, 5'(s + 8), 2'b00);
    applyStimulus(1'b1);
    checkOutput("post_rst_grant", 32'(sa_BREADY_o), 32'b001);

    $display("[TB] random traffic");
    for (int k = 0; k < 300; k++) begin
      for (int s = 0; s < N; s++)
        if (!pend_v[s] && $urandom_range(0, 1) == 1) setPend(s, 5'($urandom), 2'($urandom));
      applyStimulus($urandom_range(0, 3) != 0);
    end

`ifdef DSP_WRESP_ERR_CNT_EN
    $display("[TB] error counter");
    doReset();
    setPend(0, 5'h01, 2'b10);
    applyStimulus(1'b1);
    setPend(1, 5'h02, 2'b00);
    applyStimulus(1'b1);
    setPend(2, 5'h03, 2'b11);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("err_cnt_two", 32'(err_cnt_o), 32'd2);

    doReset();
    sa_BVALID_i = '1;
    sa_BID_i    = '0;
    sa_BRESP_i  = {N{2'b10}};
    m_BREADY_i  = 1'b1;
    repeat (65545) @(posedge clk);
    @(negedge clk);
    checkOutput("err_cnt_sat", 32'(err_cnt_o), 32'h0000FFFF);
    sa_BVALID_i = '0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
